// File: rtl/mult_dot_accumulator_if.sv
// mult_dot_accumulator_if: operand, multiplier and result ports of the dot-product accumulator.
interface mult_dot_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 18
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    modport slave (
        input  in_valid, in_a, in_b, mul_y, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_sum
    );
    modport master (
        output in_valid, in_a, in_b, mul_y, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_sum
    );
endinterface

// File: rtl/mult_dot_accumulator.sv
// mult_dot_accumulator: feeds LEN operand pairs to a fixed-latency multiplier and sums the products.
module mult_dot_accumulator #(
    parameter int WIDTH     = 8,
    parameter int LEN       = 4,
    parameter int ACC_WIDTH = 18,
    parameter int MULT_LAT  = 2
) (
    input logic                     clk,
    input logic                     rst,
    mult_dot_accumulator_if.slave   io_bus
);
    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [MULT_LAT-1:0] REST_MASK = {MULT_LAT{1'b1}} >> 1;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [MULT_LAT-1:0]  r_sr;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_out_sum;
    logic                 r_out_valid;
    logic                 w_accept;
    logic                 w_tap;
    logic                 w_rest;
    logic                 w_last;
    logic [ACC_WIDTH-1:0] w_sum;
    assign io_bus.in_ready  = (r_state == ACCUM);
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_sum   = r_out_sum;
    assign w_accept = io_bus.in_valid & io_bus.in_ready;
    // Idle cycles push zeros into the multiplier so a gap can never add a stale product.
    assign io_bus.mul_a = w_accept ? io_bus.in_a : '0;
    assign io_bus.mul_b = w_accept ? io_bus.in_b : '0;
    assign w_tap  = r_sr[MULT_LAT-1];
    assign w_rest = |(r_sr & REST_MASK);
    assign w_last = (r_cnt == CW'(LEN - 1));
    assign w_sum  = r_acc + ACC_WIDTH'(io_bus.mul_y);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_acc       <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_sr <= (r_sr << 1) | MULT_LAT'(w_accept);
            if (w_tap) r_acc <= w_sum;
            case (r_state)
                ACCUM: if (w_accept) begin
                    r_cnt <= w_last ? '0 : CW'(r_cnt + 1'b1);
                    if (w_last) r_state <= DRAIN;
                end
                DRAIN: if (w_tap && !w_rest) begin
                    r_state     <= OUT;
                    r_out_valid <= 1'b1;
                    r_out_sum   <= w_sum;
                end
                OUT: if (io_bus.out_ready) begin
                    r_acc       <= '0;
                    r_out_valid <= 1'b0;
                    r_state     <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_dot_accumulator.sv
// tb_mult_dot_accumulator: directed checks of the dot-product accumulator with a behavioural 2-stage multiplier.
module tb_mult_dot_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   lat;
    always #5 clk = ~clk;
    mult_dot_accumulator_if #(.WIDTH(8), .ACC_WIDTH(18)) bus0 ();
    mult_dot_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16)) bus1 ();
    mult_dot_accumulator #(.WIDTH(8), .LEN(4), .ACC_WIDTH(18), .MULT_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .io_bus(bus0)
    );
    mult_dot_accumulator #(.WIDTH(8), .LEN(1), .ACC_WIDTH(16), .MULT_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .io_bus(bus1)
    );
    // Multiplier models: input registers, then product registers, no reset.
    logic [7:0]  ra0, rb0, ra1, rb1;
    logic [15:0] y0, y1;
    always_ff @(posedge clk) begin
        ra0 <= bus0.mul_a;
        rb0 <= bus0.mul_b;
        y0  <= 16'(ra0) * 16'(rb0);
        ra1 <= bus1.mul_a;
        rb1 <= bus1.mul_b;
        y1  <= 16'(ra1) * 16'(rb1);
    end
    assign bus0.mul_y = y0;
    assign bus1.mul_y = y1;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic send_vec(input logic [31:0] av, input logic [31:0] bv, input int gap, output int l);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus0.in_valid = 1'b0;
                    chk("gap_in_ready", 32'(bus0.in_ready), 1);
                    step();
                end
            end
            bus0.in_valid = 1'b1;
            bus0.in_a = av[8*i +: 8];
            bus0.in_b = bv[8*i +: 8];
            chk("accum_in_ready", 32'(bus0.in_ready), 1);
            step();
        end
        bus0.in_valid = 1'b0;
        l = 0;
        while (!bus0.out_valid && l < 20) begin
            step();
            l++;
        end
    endtask
    initial begin
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(bus0.out_valid), 0);
        chk("rst_out_sum", 32'(bus0.out_sum), 0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(bus0.in_ready), 1);
        // 1: back-to-back pairs
        send_vec({8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, lat);
        chk("t1_latency", 32'(lat), 2);
        chk("t1_sum", 32'(bus0.out_sum), 100);
        chk("t1_out_in_ready", 32'(bus0.in_ready), 0);
        step();
        chk("t1_taken", 32'(bus0.out_valid), 0);
        chk("t1_back_accum", 32'(bus0.in_ready), 1);
        // 2: maximum operands
        send_vec({4{8'd255}}, {4{8'd255}}, 0, lat);
        chk("t2_latency", 32'(lat), 2);
        chk("t2_sum", 32'(bus0.out_sum), 260100);
        step();
        // 3: idle gaps between pairs, 6+20+1+42
        send_vec({8'd6, 8'd1, 8'd4, 8'd2}, {8'd7, 8'd1, 8'd5, 8'd3}, 3, lat);
        chk("t3_latency", 32'(lat), 2);
        chk("t3_sum", 32'(bus0.out_sum), 69);
        step();
        // 4: back-pressure on the result
        bus0.out_ready = 1'b0;
        send_vec({8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, lat);
        chk("t4_latency", 32'(lat), 2);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t4_hold_valid", 32'(bus0.out_valid), 1);
            chk("t4_hold_sum", 32'(bus0.out_sum), 100);
            chk("t4_hold_in_ready", 32'(bus0.in_ready), 0);
        end
        bus0.out_ready = 1'b1;
        step();
        chk("t4_taken", 32'(bus0.out_valid), 0);
        send_vec({4{8'd1}}, {4{8'd1}}, 0, lat);
        chk("t4_cleared_sum", 32'(bus0.out_sum), 4);
        step();
        // 5: reset mid-vector
        bus0.in_valid = 1'b1; bus0.in_a = 8'd9; bus0.in_b = 8'd9;
        step();
        step();
        bus0.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus0.out_valid), 0);
        chk("t5_rst_sum", 32'(bus0.out_sum), 0);
        chk("t5_rst_in_ready", 32'(bus0.in_ready), 1);
        step();
        rst = 1'b0;
        send_vec({8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, lat);
        chk("t5_latency", 32'(lat), 2);
        chk("t5_sum", 32'(bus0.out_sum), 100);
        step();
        // 6: LEN=1 instance
        chk("t6_idle_ready", 32'(bus1.in_ready), 1);
        bus1.in_valid = 1'b1; bus1.in_a = 8'd12; bus1.in_b = 8'd10;
        step();
        bus1.in_valid = 1'b0;
        chk("t6_drain_ready", 32'(bus1.in_ready), 0);
        chk("t6_drain_valid", 32'(bus1.out_valid), 0);
        step();
        chk("t6_early_valid", 32'(bus1.out_valid), 0);
        step();
        chk("t6_valid", 32'(bus1.out_valid), 1);
        chk("t6_sum", 32'(bus1.out_sum), 120);
        chk("t6_out_ready", 32'(bus1.in_ready), 0);
        bus1.out_ready = 1'b1;
        step();
        chk("t6_taken", 32'(bus1.out_valid), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
